// File: rtl/data_bus_arbiter_pkg.sv
// memory_mapping: shared address-map constants plus the types used by the
// data-bus arbiter (FSM state and latched request payload).
package memory_mapping;

    localparam logic [31:0] DATA_RAM_BEGIN = 32'h0000_4000;
    localparam logic [31:0] DATA_RAM_END   = 32'h0000_6000;
    localparam int unsigned ADDR_WIDTH     = 11;
    localparam int unsigned WORD_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } dbus_state_t;

    typedef struct packed {
        logic                  we;
        logic [31:0]           addr;
        logic [WORD_WIDTH-1:0] wdata;
        logic [3:0]            be;
    } dbus_req_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Requester and RAM-side signals of the data-bus arbiter; the arbiter takes
// the slave view, the surrounding system (CPU, loader, RAM) the master view.
interface data_bus_arbiter_if #(
    parameter int unsigned AW = memory_mapping::ADDR_WIDTH
);
    logic [1:0]    m_req;
    logic [1:0]    m_we;
    logic [31:0]   m_addr0;
    logic [31:0]   m_addr1;
    logic [31:0]   m_wdata0;
    logic [31:0]   m_wdata1;
    logic [3:0]    m_be0;
    logic [3:0]    m_be1;
    logic [1:0]    m_gnt;
    logic [1:0]    m_rvalid;
    logic          m_err;
    logic [31:0]   m_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_be;
    logic [31:0]   ram_rdata;

    modport slave (
        input  m_req, m_we, m_addr0, m_addr1, m_wdata0, m_wdata1, m_be0, m_be1,
        output m_gnt, m_rvalid, m_err, m_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, ram_be,
        input  ram_rdata
    );

    modport master (
        output m_req, m_we, m_addr0, m_addr1, m_wdata0, m_wdata1, m_be0, m_be1,
        input  m_gnt, m_rvalid, m_err, m_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, ram_be,
        output ram_rdata
    );

endinterface

// File: rtl/data_bus_arbiter_addr_decode.sv
// dbus_addr_decode: combinational check of a byte address against the data
// RAM window; yields the hit flag and the RAM word index.
module dbus_addr_decode
    import memory_mapping::*;
#(
    parameter logic [31:0] DATA_BEGIN = DATA_RAM_BEGIN,
    parameter logic [31:0] DATA_END   = DATA_RAM_END,
    parameter int unsigned AW         = ADDR_WIDTH
) (
    input  logic [31:0]   addr,
    output logic          hit,
    output logic [AW-1:0] idx
);

    always_comb begin
        hit = (addr[1:0] == 2'b00) && (addr >= DATA_BEGIN) && (addr < DATA_END);
        idx = AW'((addr - DATA_BEGIN) >> 2);
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: two-port arbiter in front of the single-port data RAM.
// Define DBUS_ARB_RR_EN for round-robin arbitration (default: port 0 priority).
module data_bus_arbiter
    import memory_mapping::*;
#(
    parameter logic [31:0] DATA_BEGIN = DATA_RAM_BEGIN,
    parameter logic [31:0] DATA_END   = DATA_RAM_END,
    parameter int unsigned AW         = ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    data_bus_arbiter_if.slave  bus
);

    dbus_state_t   state_q;
    dbus_state_t   state_d;

    logic          any_req;
    logic          winner;
    logic          grant;
    dbus_req_t     win_req;
    logic          win_hit;
    logic [AW-1:0] win_idx;

    logic          port_q;
    logic          hit_q;
    logic          we_q;

`ifdef DBUS_ARB_RR_EN
    logic          last_grant_q;
`endif

    always_comb begin : arbitrate
        any_req = |bus.m_req;
`ifdef DBUS_ARB_RR_EN
        if (&bus.m_req) begin
            winner = ~last_grant_q;
        end else begin
            winner = ~bus.m_req[0];
        end
`else
        winner = ~bus.m_req[0];
`endif
        if (winner) begin
            win_req.we    = bus.m_we[1];
            win_req.addr  = bus.m_addr1;
            win_req.wdata = bus.m_wdata1;
            win_req.be    = bus.m_be1;
        end else begin
            win_req.we    = bus.m_we[0];
            win_req.addr  = bus.m_addr0;
            win_req.wdata = bus.m_wdata0;
            win_req.be    = bus.m_be0;
        end
    end

    dbus_addr_decode #(
        .DATA_BEGIN (DATA_BEGIN),
        .DATA_END   (DATA_END),
        .AW         (AW)
    ) u_decode (
        .addr (win_req.addr),
        .hit  (win_hit),
        .idx  (win_idx)
    );

    always_comb begin : fsm_next
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        bus.m_gnt = grant ? port_onehot(winner) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_state
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM controls are loaded at the grant edge so they are live in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin : datapath
        if (!rst_n) begin
            port_q        <= 1'b0;
            hit_q         <= 1'b0;
            we_q          <= 1'b0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_be    <= '0;
            bus.m_rvalid  <= '0;
            bus.m_err     <= 1'b0;
        end else begin
            bus.ram_en   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.m_rvalid <= '0;
            bus.m_err    <= 1'b0;
            if (grant) begin
                port_q        <= winner;
                hit_q         <= win_hit;
                we_q          <= win_req.we;
                bus.ram_en    <= win_hit;
                bus.ram_we    <= win_hit & win_req.we;
                bus.ram_addr  <= win_idx;
                bus.ram_wdata <= win_req.wdata;
                bus.ram_be    <= win_req.be;
            end
            if (state_q == ISSUE) begin
                bus.m_rvalid <= port_onehot(port_q);
                bus.m_err    <= ~hit_q;
            end
        end
    end

`ifdef DBUS_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin : rr_pointer
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (grant) begin
            last_grant_q <= winner;
        end
    end
`endif

    // The RAM output register is the data register: gate it only in RESP.
    always_comb begin : read_return
        bus.m_rdata = (state_q == RESP && hit_q && !we_q) ? bus.ram_rdata : '0;
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: byte-addressed reference memory,
// directed scenarios plus randomized single-port traffic.
module tb_data_bus_arbiter;
    import memory_mapping::*;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    data_bus_arbiter_if #(.AW(ADDR_WIDTH)) bus ();

    data_bus_arbiter #(
        .DATA_BEGIN (DATA_RAM_BEGIN),
        .DATA_END   (DATA_RAM_END),
        .AW         (ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: synchronous, byte-enabled, read data one cycle after ram_en.
    bit [31:0] ram [0:2047];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_be[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
                end
            end
            bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    // Reference: memory as individual bytes keyed by byte address.
    bit [7:0] ref_bytes [int unsigned];

    function automatic logic ref_hit(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h0000_4000) && (a < 32'h0000_6000);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = ref_bytes.exists(a + b) ? ref_bytes[a + b] : 8'h00;
        end
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_bytes[a + b] = d[8*b +: 8];
        end
    endtask

    task automatic drive_port(input int p, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        if (p == 0) begin
            bus.m_addr0 = addr; bus.m_wdata0 = wdata; bus.m_be0 = be;
        end else begin
            bus.m_addr1 = addr; bus.m_wdata1 = wdata; bus.m_be1 = be;
        end
        bus.m_we[p]  = we;
        bus.m_req[p] = 1'b1;
    endtask

    // One complete single-port transaction with timing and payload checks.
    task automatic txn(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input string name, output logic [31:0] rd);
        logic        h;
        logic [31:0] exp;
        logic [10:0] idx;
        logic [1:0]  oh;
        int          n;
        h   = ref_hit(addr);
        exp = (h && !we) ? ref_read(addr) : 32'h0;
        idx = 11'((addr - 32'h0000_4000) / 4);
        oh  = (p == 0) ? 2'b01 : 2'b10;
        rd  = 32'h0;
        @(posedge clk); #1;
        drive_port(p, we, addr, wdata, be);
        #1;
        n = 0;
        while (bus.m_gnt !== oh && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        vectors++;
        if (bus.m_gnt !== oh) begin
            miscompares++;
            $display("FAIL %s grant: got %b want %b", name, bus.m_gnt, oh);
            bus.m_req = '0;
            return;
        end
        @(posedge clk); #1;
        bus.m_req[p] = 1'b0;
        vectors++;
        if (bus.ram_en !== h) begin
            miscompares++;
            $display("FAIL %s ram_en: got %b want %b", name, bus.ram_en, h);
        end
        if (h) begin
            vectors++;
            if (bus.ram_addr !== idx || bus.ram_we !== we ||
                (we && (bus.ram_wdata !== wdata || bus.ram_be !== be))) begin
                miscompares++;
                $display("FAIL %s ram_port: got addr=%h we=%b wd=%h be=%h want addr=%h we=%b wd=%h be=%h",
                         name, bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.ram_be, idx, we, wdata, be);
            end
        end
        vectors++;
        if (bus.m_rvalid !== 2'b00 || bus.m_gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL %s issue_quiet: got rvalid=%b gnt=%b want 00/00", name, bus.m_rvalid, bus.m_gnt);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.m_rvalid !== oh || bus.m_err !== !h || bus.m_rdata !== exp) begin
            miscompares++;
            $display("FAIL %s response: got rvalid=%b err=%b rdata=%h want rvalid=%b err=%b rdata=%h",
                     name, bus.m_rvalid, bus.m_err, bus.m_rdata, oh, !h, exp);
        end
        rd = bus.m_rdata;
        if (h && we) ref_write(addr, wdata, be);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.m_gnt, bus.m_rvalid, bus.m_err, bus.m_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_resp: got gnt=%b rvalid=%b err=%b rdata=%h want zeros",
                     bus.m_gnt, bus.m_rvalid, bus.m_err, bus.m_rdata);
        end
        vectors++;
        if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_be} !== '0) begin
            miscompares++;
            $display("FAIL reset_ram: got en=%b we=%b addr=%h wd=%h be=%h want zeros",
                     bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_be);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (bus.m_gnt !== 2'b00 || bus.m_rvalid !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_req: got gnt=%b rvalid=%b want 00/00", bus.m_gnt, bus.m_rvalid);
        end
    endtask

    task automatic test_priority();
        int got [4];
        int exp [4];
        int ng;
`ifdef DBUS_ARB_RR_EN
        exp = '{0, 1, 0, 1};
`else
        exp = '{0, 0, 0, 0};
`endif
        ng = 0;
        @(posedge clk); #1;
        drive_port(0, 1'b0, 32'h0000_4020, 32'h0, 4'hF);
        drive_port(1, 1'b0, 32'h0000_4024, 32'h0, 4'hF);
        #1;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            if (bus.m_gnt == 2'b01) begin got[ng] = 0; ng++; end
            else if (bus.m_gnt == 2'b10) begin got[ng] = 1; ng++; end
            @(posedge clk); #2;
        end
        bus.m_req = '0;
        repeat (2) @(posedge clk);
        vectors++;
        if (ng != 4) begin
            miscompares++;
            $display("FAIL priority_count: got %0d grants want 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
            vectors++;
            if (got[i] != exp[i]) begin
                miscompares++;
                $display("FAIL priority_grant%0d: got port %0d want port %0d", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        txn(0, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF, "wr_4000", rd);
        txn(0, 1'b0, 32'h0000_4000, 32'h0, 4'hF, "rd_4000", rd);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL readback_4000: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] rd;
        txn(1, 1'b0, 32'h0000_5FFC, 32'h0, 4'hF, "rd_last_word", rd);
        txn(1, 1'b0, 32'h0000_6000, 32'h0, 4'hF, "rd_window_end", rd);
        txn(1, 1'b1, 32'h0000_3FFC, 32'h1234_5678, 4'hF, "wr_below_window", rd);
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        txn(0, 1'b1, 32'h0000_4002, 32'hCAFE_F00D, 4'hF, "wr_misaligned", rd);
        txn(0, 1'b0, 32'h0000_4000, 32'h0, 4'hF, "rd_after_misaligned", rd);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL misaligned_untouched: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd;
        txn(0, 1'b1, 32'h0000_4010, 32'hFFFF_FFFF, 4'hF, "wr_all_ones", rd);
        txn(0, 1'b1, 32'h0000_4010, 32'h1122_3344, 4'b0010, "wr_byte1", rd);
        txn(0, 1'b0, 32'h0000_4010, 32'h0, 4'hF, "rd_byte_merge", rd);
        vectors++;
        if (rd !== 32'hFFFF_33FF) begin
            miscompares++;
            $display("FAIL byte_merge: got %h want ffff33ff", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          n;
        @(posedge clk); #1;
        drive_port(1, 1'b1, 32'h0000_4100, 32'hA5A5_A5A5, 4'hF);
        #1;
        n = 0;
        while (bus.m_gnt !== 2'b10 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        vectors++;
        if (bus.m_gnt !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_mid_grant: got %b want 10", bus.m_gnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.m_req = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (bus.m_rvalid !== 2'b00 || bus.ram_en !== 1'b0 || bus.m_gnt !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_mid_quiet: got rvalid=%b ram_en=%b gnt=%b want 00/0/00",
                         bus.m_rvalid, bus.ram_en, bus.m_gnt);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        txn(0, 1'b0, 32'h0000_4100, 32'h0, 4'hF, "rd_after_reset", rd);
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] addr;
        int          sel;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                6:       addr = 32'h0000_4000 + 4 * $urandom_range(0, 2047) + $urandom_range(1, 3);
                7:       addr = 32'h0000_4000 - 4 * $urandom_range(1, 64);
                8:       addr = 32'h0000_6000 + 4 * $urandom_range(0, 64);
                9:       addr = ($urandom_range(0, 1) == 0) ? 32'h0000_4000 : 32'h0000_5FFC;
                default: addr = 32'h0000_4000 + 4 * $urandom_range(0, 15);
            endcase
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), addr, $urandom,
                4'($urandom_range(0, 15)), "random", rd);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        bus.m_req    = '0;
        bus.m_we     = '0;
        bus.m_addr0  = '0;
        bus.m_addr1  = '0;
        bus.m_wdata0 = '0;
        bus.m_wdata1 = '0;
        bus.m_be0    = '0;
        bus.m_be1    = '0;
        test_reset();
        test_priority();
        test_write_read();
        test_boundaries();
        test_misaligned();
        test_byte_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
